bshift_seq: RTL

//  Command sequencer for the 32-bit barrel rotator. Accepts a rotate command
//  (word, amount, direction, repeat count) over a valid/ready handshake and

---
 rtl/bshift_seq_pkg.sv | 20 ++
 rtl/bshifter32_r.sv | 36 +++
 rtl/bshift_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bshift_seq_pkg.sv
// Shared definitions for the barrel-rotator command sequencer.
//   WORD_W     : width of the rotated word
//   AMT_W      : width of the per-beat rotate amount (rotation is modulo 2**AMT_W)
//   DIR_RIGHT  : lr encoding for rotate right
//   DIR_LEFT   : lr encoding for rotate left
//   state_t    : sequencer states (ST_IDLE accepts commands, ST_EMIT streams beats)
package bshift_seq_pkg;

    localparam int WORD_W = 32;
    localparam int AMT_W  = 5;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/bshifter32_r.sv
// Combinational 32-bit barrel rotator.
//   a   in  WORD_W : word to rotate
//   amt in  AMT_W  : rotate distance (0..31)
//   lr  in  1      : DIR_RIGHT rotates right, DIR_LEFT rotates left
//   y   out WORD_W : rotated word (no bits lost)
module bshifter32_r
    import bshift_seq_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [AMT_W-1:0]  amt,
    input  logic              lr,
    output logic [WORD_W-1:0] y
);

    // Logarithmic rotator: stage gi rotates by 2**gi when amt[gi] is set.
    logic [AMT_W:0][WORD_W-1:0] w_stage;

    assign w_stage[0] = a;

    genvar gi;
    generate
        for (gi = 0; gi < AMT_W; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            logic [WORD_W-1:0] w_rotr;
            logic [WORD_W-1:0] w_rotl;

            assign w_rotr = {w_stage[gi][SH-1:0], w_stage[gi][WORD_W-1:SH]};
            assign w_rotl = {w_stage[gi][WORD_W-1-SH:0], w_stage[gi][WORD_W-1:WORD_W-SH]};
            assign w_stage[gi+1] = amt[gi] ? ((lr == DIR_RIGHT) ? w_rotr : w_rotl)
                                           : w_stage[gi];
        end
    endgenerate

    assign y = w_stage[AMT_W];

endmodule

// File: rtl/bshift_seq.sv
// Command sequencer for the 32-bit barrel rotator.
// Accepts {word, amount, direction, repeat count} over a valid/ready handshake
// and streams each successively rotated word over a second valid/ready port.
//   clk        in   1      rising-edge clock
//   reset_n    in   1      asynchronous active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      high only while idle
//   cmd_data   in   32     initial word
//   cmd_amt    in   5      rotate amount per beat
//   cmd_lr     in   1      0 = right, 1 = left
//   cmd_cnt    in   CNT_W  beats to emit (0 = single unrotated pass-through beat)
//   abort      in   1      cancel running command (ignored while idle)
//   out_valid  out  1      beat present
//   out_ready  in   1      consumer takes beat
//   out_data   out  32     rotated word
//   out_last   out  1      final beat of the command
//   done       out  1      one-cycle pulse after the command finishes or aborts
module bshift_seq
    import bshift_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WORD_W-1:0] cmd_data,
    input  logic [AMT_W-1:0]  cmd_amt,
    input  logic              cmd_lr,
    input  logic [CNT_W-1:0]  cmd_cnt,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);

    state_t             r_state,  w_state_next;
    logic [WORD_W-1:0]  r_word,   w_word_next;
    logic [AMT_W-1:0]   r_amt,    w_amt_next;
    logic               r_lr,     w_lr_next;
    logic [CNT_W-1:0]   r_rem,    w_rem_next;
    logic               r_done,   w_done_next;

    logic [WORD_W-1:0]  w_rot_a;
    logic [AMT_W-1:0]   w_rot_amt;
    logic               w_rot_lr;
    logic [WORD_W-1:0]  w_rot_y;
    logic               w_is_last;

    // One shared rotator: fed from the command port while idle (first beat is
    // computed at accept time) and from the held word while emitting.
    assign w_rot_a   = (r_state == ST_IDLE) ? cmd_data : r_word;
    assign w_rot_amt = (r_state == ST_IDLE) ? cmd_amt  : r_amt;
    assign w_rot_lr  = (r_state == ST_IDLE) ? cmd_lr   : r_lr;

    bshifter32_r u_rot (
        .a   (w_rot_a),
        .amt (w_rot_amt),
        .lr  (w_rot_lr),
        .y   (w_rot_y)
    );

    assign w_is_last = (r_rem == CNT_W'(1));

    always_comb begin
        w_state_next = r_state;
        w_word_next  = r_word;
        w_amt_next   = r_amt;
        w_lr_next    = r_lr;
        w_rem_next   = r_rem;
        w_done_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_amt_next   = cmd_amt;
                    w_lr_next    = cmd_lr;
                    w_state_next = ST_EMIT;
                    if (cmd_cnt != '0) begin
                        w_word_next = w_rot_y;
                        w_rem_next  = cmd_cnt;
                    end else begin
                        // Pass-through: one unrotated beat.
                        w_word_next = cmd_data;
                        w_rem_next  = CNT_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                // An abort that coincides with a handshake still delivers that
                // beat; either way the command ends here.
                if (abort || (out_ready && w_is_last)) begin
                    w_state_next = ST_IDLE;
                    w_rem_next   = '0;   // keeps out_last low while idle
                    w_done_next  = 1'b1;
                end else if (out_ready) begin
                    w_word_next = w_rot_y;
                    w_rem_next  = r_rem - CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_word  <= '0;
            r_amt   <= '0;
            r_lr    <= 1'b0;
            r_rem   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_word  <= w_word_next;
            r_amt   <= w_amt_next;
            r_lr    <= w_lr_next;
            r_rem   <= w_rem_next;
            r_done  <= w_done_next;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_EMIT);
    assign out_data  = r_word;
    assign out_last  = w_is_last;
    assign done      = r_done;

endmodule
